// File: rtl/kv_hash_writer.sv
// kv_hash_writer: insertion engine for the two-level key/value hash store.
// Each (key, value) request probes table 1 at key % H1_BUCKETS, then table 2
// at key % H2_BUCKETS, and writes the value into the first empty bucket.
// A bucket holding 0 is empty, so a value of 0 is rejected without any
// memory access.
// Optional build macro: KV_WRITER_STATS_EN adds saturating ins_count and
// fail_count outputs.
module kv_hash_writer #(
   parameter int KEY_WIDTH     = 32,
   parameter int RAM_WIDTH     = 32,
   parameter int RAM_ADDR_BITS = 9,
   parameter int H1_BUCKETS    = 5,
   parameter int H2_BUCKETS    = 10
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [KEY_WIDTH-1:0]     in_key,
   input  logic [RAM_WIDTH-1:0]     in_value,
   output logic                     h1_en,
   output logic                     h1_we,
   output logic [RAM_ADDR_BITS-1:0] h1_addr,
   output logic [RAM_WIDTH-1:0]     h1_wdata,
   input  logic [RAM_WIDTH-1:0]     h1_rdata,
   output logic                     h2_en,
   output logic                     h2_we,
   output logic [RAM_ADDR_BITS-1:0] h2_addr,
   output logic [RAM_WIDTH-1:0]     h2_wdata,
   input  logic [RAM_WIDTH-1:0]     h2_rdata,
   output logic                     done_valid,
   output logic [1:0]               done_status,
   output logic                     busy
`ifdef KV_WRITER_STATS_EN
   ,
   output logic [15:0]              ins_count,
   output logic [15:0]              fail_count
`endif
);

   typedef enum logic [2:0] {IDLE, RD1, CHK1, CHK2, DONE} state_t;
   typedef enum logic [1:0] {ST_T1 = 2'd0, ST_T2 = 2'd1, ST_FULL = 2'd2, ST_ZERO = 2'd3} status_t;

   localparam logic [KEY_WIDTH-1:0] H1_MOD = KEY_WIDTH'(H1_BUCKETS);
   localparam logic [KEY_WIDTH-1:0] H2_MOD = KEY_WIDTH'(H2_BUCKETS);

   state_t                   state_q, state_d;
   status_t                  status_q, status_d;
   logic [RAM_WIDTH-1:0]     value_q, value_d;
   logic [RAM_ADDR_BITS-1:0] idx1_q, idx1_d, idx2_q, idx2_d;
   logic [RAM_ADDR_BITS-1:0] h1_addr_q, h2_addr_q;
   logic [RAM_WIDTH-1:0]     h1_wdata_q, h2_wdata_q;
   logic                     accept;
   logic                     h1_empty, h2_empty;

   assign in_ready    = (state_q == IDLE) && !reset;
   assign busy        = (state_q != IDLE);
   assign accept      = in_valid && in_ready;
   assign done_valid  = (state_q == DONE);
   assign done_status = status_q;
   assign h1_empty    = (h1_rdata == '0);
   assign h2_empty    = (h2_rdata == '0);

   // Next-state, request latch and outcome selection.
   always_comb begin
      // NOTE: every variable gets a hold default first so no path leaves it unassigned (no latch).
      state_d  = state_q;
      status_d = status_q;
      value_d  = value_q;
      idx1_d   = idx1_q;
      idx2_d   = idx2_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               value_d = in_value;
               idx1_d  = RAM_ADDR_BITS'(in_key % H1_MOD);
               idx2_d  = RAM_ADDR_BITS'(in_key % H2_MOD);
               if (in_value == '0) begin
                  status_d = ST_ZERO;
                  state_d  = DONE;
               end else begin
                  state_d  = RD1;
               end
            end
         end
         RD1:  state_d = CHK1;
         CHK1: begin
            if (h1_empty) begin
               status_d = ST_T1;
               state_d  = DONE;
            end else begin
               state_d  = CHK2;
            end
         end
         CHK2: begin
            status_d = h2_empty ? ST_T2 : ST_FULL;
            state_d  = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Memory strobes come from the state register and the returned read data;
   // address and write data follow the latched request while enabled and hold otherwise.
   always_comb begin
      h1_en    = (state_q == RD1) || ((state_q == CHK1) && h1_empty);
      h1_we    = (state_q == CHK1) && h1_empty;
      h2_en    = ((state_q == CHK1) && !h1_empty) || ((state_q == CHK2) && h2_empty);
      h2_we    = (state_q == CHK2) && h2_empty;
      h1_addr  = h1_en ? idx1_q : h1_addr_q;
      h1_wdata = h1_we ? value_q : h1_wdata_q;
      h2_addr  = h2_en ? idx2_q : h2_addr_q;
      h2_wdata = h2_we ? value_q : h2_wdata_q;
   end

   // State, latched request and held memory-port values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         status_q   <= ST_T1;
         value_q    <= '0;
         idx1_q     <= '0;
         idx2_q     <= '0;
         h1_addr_q  <= '0;
         h1_wdata_q <= '0;
         h2_addr_q  <= '0;
         h2_wdata_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q    <= state_d;
         status_q   <= status_d;
         value_q    <= value_d;
         idx1_q     <= idx1_d;
         idx2_q     <= idx2_d;
         h1_addr_q  <= h1_addr;
         h1_wdata_q <= h1_wdata;
         h2_addr_q  <= h2_addr;
         h2_wdata_q <= h2_wdata;
      end
   end

`ifdef KV_WRITER_STATS_EN
   logic [15:0] ins_count_q, ins_count_d;
   logic [15:0] fail_count_q, fail_count_d;

   // Saturating completion counters, stepped in the DONE cycle.
   always_comb begin
      ins_count_d  = ins_count_q;
      fail_count_d = fail_count_q;
      if (state_q == DONE) begin
         if (status_q == ST_T1 || status_q == ST_T2) begin
            if (ins_count_q != 16'hFFFF) ins_count_d = ins_count_q + 16'd1;
         end else begin
            if (fail_count_q != 16'hFFFF) fail_count_d = fail_count_q + 16'd1;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ins_count_q  <= '0;
         fail_count_q <= '0;
      end else begin
         ins_count_q  <= ins_count_d;
         fail_count_q <= fail_count_d;
      end
   end

   assign ins_count  = ins_count_q;
   assign fail_count = fail_count_q;
`endif

endmodule

// File: tb/tb_kv_hash_writer.sv
// Self-checking bench for kv_hash_writer: directed scenarios followed by
// randomized inserts, checked against a table-level reference model.
module tb_kv_hash_writer;

   localparam int H1 = 5;
   localparam int H2 = 10;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_key = '0;
   logic [31:0] in_value = '0;
   logic        h1_en, h1_we, h2_en, h2_we;
   logic [8:0]  h1_addr, h2_addr;
   logic [31:0] h1_wdata, h2_wdata;
   logic [31:0] h1_rdata, h2_rdata;
   logic        done_valid;
   logic [1:0]  done_status;
   logic        busy;
`ifdef KV_WRITER_STATS_EN
   logic [15:0] ins_count, fail_count;
`endif

   kv_hash_writer dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_value(in_value),
      .h1_en(h1_en), .h1_we(h1_we), .h1_addr(h1_addr), .h1_wdata(h1_wdata), .h1_rdata(h1_rdata),
      .h2_en(h2_en), .h2_we(h2_we), .h2_addr(h2_addr), .h2_wdata(h2_wdata), .h2_rdata(h2_rdata),
      .done_valid(done_valid), .done_status(done_status), .busy(busy)
`ifdef KV_WRITER_STATS_EN
      , .ins_count(ins_count), .fail_count(fail_count)
`endif
   );

   always #5 clock = ~clock;

   // Synchronous BRAM models plus activity counters.
   logic [31:0] mem1 [0:511];
   logic [31:0] mem2 [0:511];
   logic        clear_req = 1'b0;
   int          wr_cnt = 0, en_cnt = 0, done_cnt = 0;

   always @(posedge clock) begin
      if (clear_req) begin
         for (int a = 0; a < 512; a++) begin
            mem1[a] <= '0;
            mem2[a] <= '0;
         end
      end else begin
         if (h1_en) begin
            if (h1_we) mem1[h1_addr] <= h1_wdata;
            else       h1_rdata <= mem1[h1_addr];
         end
         if (h2_en) begin
            if (h2_we) mem2[h2_addr] <= h2_wdata;
            else       h2_rdata <= mem2[h2_addr];
         end
      end
      wr_cnt   <= wr_cnt + int'(h1_en && h1_we) + int'(h2_en && h2_we);
      en_cnt   <= en_cnt + int'(h1_en) + int'(h2_en);
      done_cnt <= done_cnt + int'(done_valid);
   end

   // Reference model: the two tables as plain arrays of bucket contents.
   logic [31:0] m1 [0:H1-1];
   logic [31:0] m2 [0:H2-1];
   int n_cmp = 0, n_mis = 0;
   int exp_ins = 0, exp_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int a = 0; a < H1; a++) m1[a] = '0;
      for (int a = 0; a < H2; a++) m2[a] = '0;
      exp_ins  = 0;
      exp_fail = 0;
   endtask

   // Outcome and completion latency (cycles after accept) from the table rules.
   task automatic model_insert(input logic [31:0] k, input logic [31:0] v,
                               output logic [1:0] st, output int lat);
      int i1, i2;
      i1 = int'(k % H1);
      i2 = int'(k % H2);
      if (v == 0) begin
         st = 2'd3; lat = 1; exp_fail++;
      end else if (m1[i1] == 0) begin
         st = 2'd0; lat = 3; m1[i1] = v; exp_ins++;
      end else if (m2[i2] == 0) begin
         st = 2'd1; lat = 4; m2[i2] = v; exp_ins++;
      end else begin
         st = 2'd2; lat = 4; exp_fail++;
      end
   endtask

   task automatic pulse_reset_and_clear();
      @(negedge clock);
      reset = 1'b1; clear_req = 1'b1;
      @(negedge clock);
      clear_req = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      model_clear();
   endtask

   // One insert from the IDLE negedge through the cycle after DONE.
   task automatic insert(input logic [31:0] k, input logic [31:0] v);
      logic [1:0] es;
      int lat, i1, i2, w0, e0;
      i1 = int'(k % H1);
      i2 = int'(k % H2);
      model_insert(k, v, es, lat);
      check("ready_idle", in_ready, 1);
      w0 = wr_cnt; e0 = en_cnt;
      in_valid = 1'b1; in_key = k; in_value = v;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0; in_key = $urandom; in_value = $urandom;
      for (int c = 1; c <= lat; c++) begin
         if (c > 1) @(negedge clock);
         check("ready_busy", in_ready, 0);
         check("busy", busy, 1);
         check("done_valid", done_valid, 32'(c == lat));
         if (c == lat) check("done_status", done_status, es);
         if (c == 1 && v != 0) begin
            check("h1_rd_en", {h1_en, h1_we}, 2'b10);
            check("h1_rd_addr", h1_addr, i1);
         end
         if (c == 2 && es == 2'd0) begin
            check("h1_wr_en", {h1_en, h1_we}, 2'b11);
            check("h1_wr_addr", h1_addr, i1);
            check("h1_wdata", h1_wdata, v);
         end
         if (c == 2 && (es == 2'd1 || es == 2'd2)) begin
            check("h2_rd_en", {h2_en, h2_we, h1_we}, 3'b100);
            check("h2_rd_addr", h2_addr, i2);
         end
         if (c == 3 && es == 2'd1) begin
            check("h2_wr_en", {h2_en, h2_we}, 2'b11);
            check("h2_wr_addr", h2_addr, i2);
            check("h2_wdata", h2_wdata, v);
         end
         if (c == 3 && es == 2'd2) check("full_no_we", {h1_we, h2_we}, 2'b00);
      end
      @(negedge clock);
      check("ready_after", in_ready, 1);
      check("done_low_after", done_valid, 0);
      check("write_count", wr_cnt - w0, (es < 2'd2) ? 1 : 0);
      if (v == 0) check("zero_no_access", en_cnt - e0, 0);
      check("h1_content", mem1[i1], m1[i1]);
      check("h2_content", mem2[i2], m2[i2]);
   endtask

   initial begin
      int w0, d0, i, cyc;
      int acc [4];
      logic [31:0] bk [4];
      logic [31:0] bv [4];
      logic [31:0] k, v;

      // Reset state while reset is asserted.
      clear_req = 1'b1;
      model_clear();
      @(negedge clock);
      clear_req = 1'b0;
      @(negedge clock);
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", {done_valid, done_status}, 3'b000);
      check("rst_en_we", {h1_en, h1_we, h2_en, h2_we}, 4'b0000);
      check("rst_addr", {h1_addr, h2_addr}, 0);
      check("rst_wdata", h1_wdata | h2_wdata, 0);
      reset = 1'b0;
      @(negedge clock);
      check("rst_release_ready", in_ready, 1);

      // Directed sequence from the bring-up plan.
      insert(32'd7,  32'h40);
      insert(32'd12, 32'h41);
      insert(32'd17, 32'h42);
      insert(32'd22, 32'h43);
      insert(32'd3,  32'h0);

      // Reset during CHK1 aborts the request.
      w0 = wr_cnt; d0 = done_cnt;
      in_valid = 1'b1; in_key = 32'd4; in_value = 32'h55;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("abort_no_we", {h1_en, h1_we, h2_en, h2_we}, 4'b0000);
      check("abort_busy", busy, 0);
      check("abort_ready", in_ready, 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      check("abort_ready_release", in_ready, 1);
      check("abort_no_write", wr_cnt - w0, 0);
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_mem", mem1[4], 0);
      exp_ins = 0; exp_fail = 0;
      @(negedge clock);
      insert(32'd4, 32'h55);

      // Four back-to-back table-1 hits with in_valid held high.
      pulse_reset_and_clear();
      for (int j = 0; j < 4; j++) begin
         bk[j] = 32'(10 * j + j);
         bv[j] = $urandom | 32'd1;
      end
      d0 = done_cnt; i = 0; cyc = 0;
      while (i < 4 && cyc < 60) begin
         @(negedge clock);
         cyc++;
         in_valid = 1'b1; in_key = bk[i]; in_value = bv[i];
         if (in_ready) begin
            acc[i] = cyc;
            i++;
         end
      end
      check("b2b_all_accepted", i, 4);
      @(negedge clock);
      in_valid = 1'b0;
      repeat (4) @(negedge clock);
      for (int j = 1; j < i; j++) check("b2b_spacing", acc[j] - acc[j-1], 4);
      check("b2b_done_count", done_cnt - d0, 4);
      for (int j = 0; j < 4; j++) begin
         check("b2b_mem", mem1[int'(bk[j] % H1)], bv[j]);
         m1[int'(bk[j] % H1)] = bv[j];
      end
      exp_ins = 4;
`ifdef KV_WRITER_STATS_EN
      check("b2b_ins_count", ins_count, 16'd4);
      check("b2b_fail_count", fail_count, 16'd0);
`endif

      // Randomized inserts: small keys for collisions, some wide keys and zero values.
      for (int n = 0; n < 40; n++) begin
         k = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
         v = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom | 32'd1);
         insert(k, v);
      end
`ifdef KV_WRITER_STATS_EN
      check("final_ins_count", ins_count, exp_ins);
      check("final_fail_count", fail_count, exp_fail);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
